demux_rr_sched: RTL and testbench

Round-robin scheduler that sequences a 1:2 demux datapath. Distributes an incoming word stream across two output lanes with per-lane burst length and per-lane backpressure (pause). Contains a one-word holding register so that no word is lost when both lanes stall. Sits between the upstream word source and two downstream lane FIFOs.

---
 rtl/demux_pkg.sv | 15 +
 rtl/demux_lane_pick.sv | 52 +++++
 rtl/demux_rr_sched.sv | 100 ++++++++++
 tb/tb_demux_rr_sched.sv | 322 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/demux_pkg.sv
// Shared constants for the round-robin demux scheduler: lane ids, FSM
// state encoding and burst counter width.
package demux_pkg;

    localparam logic LANE0 = 1'b0;
    localparam logic LANE1 = 1'b1;

    localparam int unsigned BURST_CNT_W = 4;

    typedef enum logic {
        RUN   = 1'b0,
        STALL = 1'b1
    } state_e;

endpackage

// File: rtl/demux_lane_pick.sv
// Lane arbitration: picks the preferred lane if free, else the other one,
// and advances the round-robin pointer only on dispatches to the preferred lane.
module demux_lane_pick
    import demux_pkg::*;
#(
    parameter int unsigned BURST = 1
) (
    input  logic clk,
    input  logic reset_L,
    input  logic cand_valid,
    input  logic pause0,
    input  logic pause1,
    output logic pick_valid,
    output logic pick_lane,
    output logic lane_sel
);

    logic                   lane_sel_q, lane_sel_d;
    logic [BURST_CNT_W-1:0] burst_cnt_q, burst_cnt_d;
    logic                   pref_free, other_free;

    always_comb begin
        pref_free   = (lane_sel_q == LANE0) ? !pause0 : !pause1;
        other_free  = (lane_sel_q == LANE0) ? !pause1 : !pause0;
        pick_valid  = cand_valid && (pref_free || other_free);
        pick_lane   = pref_free ? lane_sel_q : ~lane_sel_q;
        lane_sel_d  = lane_sel_q;
        burst_cnt_d = burst_cnt_q;
        // Detours to the other lane leave the pointer alone so the skipped lane keeps its turn.
        if (pick_valid && pref_free) begin
            if (burst_cnt_q == BURST_CNT_W'(BURST - 1)) begin
                lane_sel_d  = ~lane_sel_q;
                burst_cnt_d = '0;
            end else begin
                burst_cnt_d = burst_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            lane_sel_q  <= LANE0;
            burst_cnt_q <= '0;
        end else begin
            lane_sel_q  <= lane_sel_d;
            burst_cnt_q <= burst_cnt_d;
        end
    end

    assign lane_sel = lane_sel_q;

endmodule

// File: rtl/demux_rr_sched.sv
// Round-robin 1:2 demux scheduler with per-lane pause and a one-word
// holding register that absorbs a word when both lanes stall.
module demux_rr_sched
    import demux_pkg::*;
#(
    parameter int unsigned W     = 8,
    parameter int unsigned BURST = 1
) (
    input  logic         clk,
    input  logic         reset_L,
    input  logic [W-1:0] data_in,
    input  logic         valid_in,
    output logic         ready_out,
    input  logic         pause0,
    input  logic         pause1,
    output logic [W-1:0] data_out0,
    output logic         valid_out0,
    output logic [W-1:0] data_out1,
    output logic         valid_out1,
    output logic         lane_sel
);

    state_e       state_q, state_d;
    logic [W-1:0] hold_q, hold_d;
    logic         ready_q, ready_d;
    logic [W-1:0] data0_q, data0_d, data1_q, data1_d;
    logic         valid0_q, valid0_d, valid1_q, valid1_d;

    logic         cand_valid;
    logic [W-1:0] cand_data;
    logic         pick_valid, pick_lane;

    demux_lane_pick #(
        .BURST(BURST)
    ) u_lane_pick (
        .clk       (clk),
        .reset_L   (reset_L),
        .cand_valid(cand_valid),
        .pause0    (pause0),
        .pause1    (pause1),
        .pick_valid(pick_valid),
        .pick_lane (pick_lane),
        .lane_sel  (lane_sel)
    );

    always_comb begin
        // A held word always wins over new input; ready_q is low in STALL anyway.
        cand_valid = (state_q == STALL) || (valid_in && ready_q);
        cand_data  = (state_q == STALL) ? hold_q : data_in;
        state_d    = state_q;
        hold_d     = hold_q;
        ready_d    = ready_q;
        data0_d    = '0;
        valid0_d   = 1'b0;
        data1_d    = '0;
        valid1_d   = 1'b0;
        if (pick_valid) begin
            if (pick_lane == LANE0) begin
                data0_d  = cand_data;
                valid0_d = 1'b1;
            end else begin
                data1_d  = cand_data;
                valid1_d = 1'b1;
            end
            state_d = RUN;
            ready_d = 1'b1;
        end else if (cand_valid) begin
            state_d = STALL;
            hold_d  = cand_data;
            ready_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            state_q  <= RUN;
            hold_q   <= '0;
            ready_q  <= 1'b1;
            data0_q  <= '0;
            valid0_q <= 1'b0;
            data1_q  <= '0;
            valid1_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            hold_q   <= hold_d;
            ready_q  <= ready_d;
            data0_q  <= data0_d;
            valid0_q <= valid0_d;
            data1_q  <= data1_d;
            valid1_q <= valid1_d;
        end
    end

    assign ready_out  = ready_q;
    assign data_out0  = data0_q;
    assign valid_out0 = valid0_q;
    assign data_out1  = data1_q;
    assign valid_out1 = valid1_q;

endmodule

// File: tb/tb_demux_rr_sched.sv
// Directed and soak bench for demux_rr_sched; a BURST=1 and a BURST=3
// instance share the same stimulus.
module tb_demux_rr_sched;

    logic       clk = 1'b0;
    logic       reset_L = 1'b0;
    logic [7:0] data_in = '0;
    logic       valid_in = 1'b0;
    logic       pause0 = 1'b0;
    logic       pause1 = 1'b0;

    logic       ready_out, valid_out0, valid_out1, lane_sel;
    logic [7:0] data_out0, data_out1;
    logic       ready_out3, valid_out0_3, valid_out1_3, lane_sel3;
    logic [7:0] data_out0_3, data_out1_3;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    demux_rr_sched #(.W(8), .BURST(1)) dut (
        .clk       (clk),
        .reset_L   (reset_L),
        .data_in   (data_in),
        .valid_in  (valid_in),
        .ready_out (ready_out),
        .pause0    (pause0),
        .pause1    (pause1),
        .data_out0 (data_out0),
        .valid_out0(valid_out0),
        .data_out1 (data_out1),
        .valid_out1(valid_out1),
        .lane_sel  (lane_sel)
    );

    demux_rr_sched #(.W(8), .BURST(3)) dut3 (
        .clk       (clk),
        .reset_L   (reset_L),
        .data_in   (data_in),
        .valid_in  (valid_in),
        .ready_out (ready_out3),
        .pause0    (pause0),
        .pause1    (pause1),
        .data_out0 (data_out0_3),
        .valid_out0(valid_out0_3),
        .data_out1 (data_out1_3),
        .valid_out1(valid_out1_3),
        .lane_sel  (lane_sel3)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        valid_in = 1'b0;
        pause0   = 1'b0;
        pause1   = 1'b0;
        data_in  = '0;
        reset_L  = 1'b0;
        step();
        step();
        reset_L = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (ready_out !== 1'b1) begin
            failures++; $display("FAIL reset_ready got=%b want=1", ready_out);
        end
        checks++;
        if (valid_out0 !== 1'b0 || valid_out1 !== 1'b0) begin
            failures++; $display("FAIL reset_valid got=%b%b want=00", valid_out0, valid_out1);
        end
        checks++;
        if (data_out0 !== 8'h00 || data_out1 !== 8'h00) begin
            failures++; $display("FAIL reset_data got=%h/%h want=00/00", data_out0, data_out1);
        end
        checks++;
        if (lane_sel !== 1'b0 || lane_sel3 !== 1'b0) begin
            failures++; $display("FAIL reset_lane_sel got=%b/%b want=0/0", lane_sel, lane_sel3);
        end
    endtask

    task automatic test_round_robin();
        logic [7:0] vec [4];
        logic       exp_lane;
        vec[0] = 8'hA1; vec[1] = 8'hB2; vec[2] = 8'hC3; vec[3] = 8'hD4;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            data_in  = vec[i];
            valid_in = 1'b1;
            step();
            exp_lane = i[0];
            checks++;
            if (exp_lane == 1'b0 && (valid_out0 !== 1'b1 || data_out0 !== vec[i] ||
                                     valid_out1 !== 1'b0)) begin
                failures++;
                $display("FAIL rr_lane0_w%0d got v0=%b d0=%h v1=%b want v0=1 d0=%h v1=0",
                         i, valid_out0, data_out0, valid_out1, vec[i]);
            end
            if (exp_lane == 1'b1 && (valid_out1 !== 1'b1 || data_out1 !== vec[i] ||
                                     valid_out0 !== 1'b0)) begin
                failures++;
                $display("FAIL rr_lane1_w%0d got v1=%b d1=%h v0=%b want v1=1 d1=%h v0=0",
                         i, valid_out1, data_out1, valid_out0, vec[i]);
            end
            checks++;
            if (lane_sel !== ~exp_lane) begin
                failures++; $display("FAIL rr_lane_sel_w%0d got=%b want=%b", i, lane_sel, ~exp_lane);
            end
        end
        valid_in = 1'b0;
        step();
        checks++;
        if (valid_out0 !== 1'b0 || valid_out1 !== 1'b0 || data_out0 !== 8'h00 ||
            data_out1 !== 8'h00 || lane_sel !== 1'b0) begin
            failures++;
            $display("FAIL rr_idle got v=%b%b d=%h/%h sel=%b want v=00 d=00/00 sel=0",
                     valid_out0, valid_out1, data_out0, data_out1, lane_sel);
        end
    endtask

    task automatic test_pause_skip();
        do_reset();
        pause1 = 1'b1;
        for (int i = 0; i < 3; i++) begin
            data_in  = 8'h10 + 8'(i);
            valid_in = 1'b1;
            step();
            checks++;
            if (valid_out0 !== 1'b1 || data_out0 !== 8'h10 + 8'(i) || valid_out1 !== 1'b0) begin
                failures++;
                $display("FAIL skip_w%0d got v0=%b d0=%h v1=%b want v0=1 d0=%h v1=0",
                         i, valid_out0, data_out0, valid_out1, 8'h10 + 8'(i));
            end
            checks++;
            if (lane_sel !== 1'b1) begin
                failures++; $display("FAIL skip_lane_sel_w%0d got=%b want=1", i, lane_sel);
            end
        end
        valid_in = 1'b0;
        pause1   = 1'b0;
    endtask

    task automatic test_full_stall();
        do_reset();
        pause0   = 1'b1;
        pause1   = 1'b1;
        data_in  = 8'h55;
        valid_in = 1'b1;
        step();
        valid_in = 1'b0;
        data_in  = 8'hEE;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (ready_out !== 1'b0 || valid_out0 !== 1'b0 || valid_out1 !== 1'b0) begin
                failures++;
                $display("FAIL stall_c%0d got rdy=%b v=%b%b want rdy=0 v=00",
                         i, ready_out, valid_out0, valid_out1);
            end
            if (i < 2) step();
        end
        pause0 = 1'b0;
        step();
        checks++;
        if (valid_out0 !== 1'b1 || data_out0 !== 8'h55 || valid_out1 !== 1'b0) begin
            failures++;
            $display("FAIL stall_drain got v0=%b d0=%h v1=%b want v0=1 d0=55 v1=0",
                     valid_out0, data_out0, valid_out1);
        end
        step();
        checks++;
        if (ready_out !== 1'b1 || valid_out0 !== 1'b0 || valid_out1 !== 1'b0) begin
            failures++;
            $display("FAIL stall_resume got rdy=%b v=%b%b want rdy=1 v=00",
                     ready_out, valid_out0, valid_out1);
        end
        pause1 = 1'b0;
    endtask

    task automatic test_burst();
        do_reset();
        for (int i = 0; i < 6; i++) begin
            data_in  = 8'h01 + 8'(i);
            valid_in = 1'b1;
            step();
            checks++;
            if (i < 3 && (valid_out0_3 !== 1'b1 || data_out0_3 !== 8'h01 + 8'(i) ||
                          valid_out1_3 !== 1'b0)) begin
                failures++;
                $display("FAIL burst_lane0_w%0d got v0=%b d0=%h v1=%b want v0=1 d0=%h v1=0",
                         i, valid_out0_3, data_out0_3, valid_out1_3, 8'h01 + 8'(i));
            end
            if (i >= 3 && (valid_out1_3 !== 1'b1 || data_out1_3 !== 8'h01 + 8'(i) ||
                           valid_out0_3 !== 1'b0)) begin
                failures++;
                $display("FAIL burst_lane1_w%0d got v1=%b d1=%h v0=%b want v1=1 d1=%h v0=0",
                         i, valid_out1_3, data_out1_3, valid_out0_3, 8'h01 + 8'(i));
            end
            checks++;
            if (lane_sel3 !== ((i >= 2 && i < 5) ? 1'b1 : 1'b0)) begin
                failures++;
                $display("FAIL burst_lane_sel_w%0d got=%b want=%b",
                         i, lane_sel3, (i >= 2 && i < 5) ? 1'b1 : 1'b0);
            end
        end
        valid_in = 1'b0;
    endtask

    task automatic test_reset_mid_stall();
        do_reset();
        data_in  = 8'h33;
        valid_in = 1'b1;
        step();
        pause0   = 1'b1;
        pause1   = 1'b1;
        data_in  = 8'h77;
        step();
        valid_in = 1'b0;
        #2;
        reset_L = 1'b0;
        #1;
        checks++;
        if (valid_out0 !== 1'b0 || valid_out1 !== 1'b0 || data_out0 !== 8'h00 ||
            data_out1 !== 8'h00 || lane_sel !== 1'b0 || ready_out !== 1'b1) begin
            failures++;
            $display("FAIL async_reset got v=%b%b d=%h/%h sel=%b rdy=%b want v=00 d=00/00 sel=0 rdy=1",
                     valid_out0, valid_out1, data_out0, data_out1, lane_sel, ready_out);
        end
        step();
        reset_L = 1'b1;
        pause0  = 1'b0;
        pause1  = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            checks++;
            if (valid_out0 !== 1'b0 || valid_out1 !== 1'b0 || ready_out !== 1'b1 ||
                lane_sel !== 1'b0) begin
                failures++;
                $display("FAIL held_discard_c%0d got v=%b%b d=%h/%h rdy=%b sel=%b want v=00 rdy=1 sel=0",
                         i, valid_out0, valid_out1, data_out0, data_out1, ready_out, lane_sel);
            end
        end
    endtask

    task automatic test_random_soak();
        logic [7:0] q[$];
        logic [7:0] exp;
        logic       p0, p1;
        int         pushed = 0;
        int         cyc = 0;
        do_reset();
        while ((pushed < 200 || q.size() != 0) && cyc < 5000) begin
            if (pushed < 200) begin
                valid_in = ($urandom_range(0, 3) != 0);
                data_in  = 8'($urandom);
                pause0   = ($urandom_range(0, 2) == 0);
                pause1   = ($urandom_range(0, 2) == 0);
            end else begin
                valid_in = 1'b0;
                pause0   = 1'b0;
                pause1   = 1'b0;
            end
            if (valid_in && ready_out) begin
                q.push_back(data_in);
                pushed++;
            end
            p0 = pause0;
            p1 = pause1;
            step();
            cyc++;
            checks++;
            if (valid_out0 && valid_out1) begin
                failures++; $display("FAIL soak_both_valid cyc=%0d got=11 want=at most one", cyc);
            end
            if (valid_out0) begin
                checks++;
                exp = (q.size() != 0) ? q.pop_front() : 8'hxx;
                if (p0 || data_out0 !== exp) begin
                    failures++;
                    $display("FAIL soak_lane0 cyc=%0d got=%h paused=%b want=%h unpaused",
                             cyc, data_out0, p0, exp);
                end
            end
            if (valid_out1) begin
                checks++;
                exp = (q.size() != 0) ? q.pop_front() : 8'hxx;
                if (p1 || data_out1 !== exp) begin
                    failures++;
                    $display("FAIL soak_lane1 cyc=%0d got=%h paused=%b want=%h unpaused",
                             cyc, data_out1, p1, exp);
                end
            end
        end
        checks++;
        if (pushed != 200 || q.size() != 0) begin
            failures++;
            $display("FAIL soak_complete got accepted=%0d pending=%0d want accepted=200 pending=0",
                     pushed, q.size());
        end
        valid_in = 1'b0;
        pause0   = 1'b0;
        pause1   = 1'b0;
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_pause_skip();
        test_full_stall();
        test_burst();
        test_reset_mid_stall();
        test_random_soak();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
